// File: rtl/dice_roll_sequencer_if.sv
// Signal bundle between the dice roll sequencer, the button pad, the value counter
// and the LED encoder.
interface dice_roll_sequencer_if;
    logic       Roll;
    logic [2:0] DiceValue;
    logic       Step;
    logic [2:0] DispValue;
    logic       Blank;
    logic       Rolling;
    logic       Error;

    modport master (
        input  Roll,
        input  DiceValue,
        output Step,
        output DispValue,
        output Blank,
        output Rolling,
        output Error
    );

    modport slave (
        output Roll,
        output DiceValue,
        input  Step,
        input  DispValue,
        input  Blank,
        input  Rolling,
        input  Error
    );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Sequences one roll of the electronic die: debounced Roll button, stepping while held,
// slow-down after release, result display and blanking after an idle timeout.
module dice_roll_sequencer #(
    parameter int CW          = 16,
    parameter int DEB_CYCLES  = 4,
    parameter int ROLL_DIV    = 3,
    parameter int NUM_SLOW    = 3,
    parameter int SHOW_CYCLES = 20
) (
    input logic                   Clock,
    input logic                   nReset,
    dice_roll_sequencer_if.master dice
);

    typedef enum logic [1:0] {
        SLEEP,
        SHOW,
        ROLL,
        SLOW
    } state_t;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] ROLL_LAST = CW'(ROLL_DIV - 1);
    localparam logic [CW-1:0] ROLL_STEP = CW'(ROLL_DIV);
    localparam logic [CW-1:0] SLOW_LAST = CW'(NUM_SLOW);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

    logic          rollMeta;
    logic          rollSync;
    logic          debLevel;
    logic [CW-1:0] debCount;
    logic          debToggle;
    logic          pressEvt;
    logic          releaseEvt;

    state_t        state;
    logic [CW-1:0] timer;
    logic [CW-1:0] slowTarget;
    logic [CW-1:0] slowIndex;
    logic          stepReg;
    logic          blankReg;
    logic          rollingReg;

    logic          stepDly;
    logic [2:0]    dispReg;
    logic          errorReg;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    // Press/release fire on the same edge the debounced level flips, so the FSM
    // reacts 2+DEB_CYCLES cycles after the raw button changes.
    assign debToggle  = (rollSync != debLevel) && (debCount == DEB_LAST);
    assign pressEvt   = debToggle && rollSync;
    assign releaseEvt = debToggle && !rollSync;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rollMeta <= 1'b0;
            rollSync <= 1'b0;
            debLevel <= 1'b0;
            debCount <= '0;
        end else begin
            rollMeta <= dice.Roll;
            rollSync <= rollMeta;
            if (rollSync == debLevel) begin
                debCount <= '0;
            end else if (debToggle) begin
                debLevel <= ~debLevel;
                debCount <= '0;
            end else begin
                debCount <= satInc(debCount);
            end
        end
    end

    // slowTarget holds k*ROLL_DIV for the pending slow-down step k.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= SLEEP;
            timer      <= '0;
            slowTarget <= '0;
            slowIndex  <= '0;
            stepReg    <= 1'b0;
            blankReg   <= 1'b1;
            rollingReg <= 1'b0;
        end else begin
            stepReg <= 1'b0;
            case (state)
                SLEEP: begin
                    if (pressEvt) begin
                        state      <= ROLL;
                        timer      <= '0;
                        blankReg   <= 1'b0;
                        rollingReg <= 1'b1;
                    end
                end
                SHOW: begin
                    if (pressEvt) begin
                        state      <= ROLL;
                        timer      <= '0;
                        rollingReg <= 1'b1;
                    end else if (timer == SHOW_LAST) begin
                        state    <= SLEEP;
                        timer    <= '0;
                        blankReg <= 1'b1;
                    end else begin
                        timer <= satInc(timer);
                    end
                end
                ROLL: begin
                    if (timer == ROLL_LAST) begin
                        stepReg <= 1'b1;
                        timer   <= '0;
                    end else begin
                        timer <= satInc(timer);
                    end
                    if (releaseEvt) begin
                        state      <= SLOW;
                        timer      <= '0;
                        slowTarget <= ROLL_STEP;
                        slowIndex  <= ONE;
                    end
                end
                SLOW: begin
                    if (timer == slowTarget - ONE) begin
                        stepReg <= 1'b1;
                        timer   <= '0;
                        if (slowIndex == SLOW_LAST) begin
                            state      <= SHOW;
                            rollingReg <= 1'b0;
                        end else begin
                            slowIndex  <= satInc(slowIndex);
                            slowTarget <= slowTarget + ROLL_STEP;
                        end
                    end else begin
                        timer <= satInc(timer);
                    end
                end
                default: begin
                    state      <= SLEEP;
                    timer      <= '0;
                    blankReg   <= 1'b1;
                    rollingReg <= 1'b0;
                end
            endcase
        end
    end

    // Sample one cycle after Step so the counter has already advanced.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stepDly  <= 1'b0;
            dispReg  <= 3'd1;
            errorReg <= 1'b0;
        end else begin
            stepDly <= stepReg;
            if (stepDly) begin
                if (dice.DiceValue != 3'd0 && dice.DiceValue != 3'd7) begin
                    dispReg <= dice.DiceValue;
                end else begin
                    errorReg <= 1'b1;
                end
            end
        end
    end

    assign dice.Step      = stepReg;
    assign dice.DispValue = dispReg;
    assign dice.Blank     = blankReg;
    assign dice.Rolling   = rollingReg;
    assign dice.Error     = errorReg;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Self-checking bench for dice_roll_sequencer: roll scenario table, a face-capture
// scoreboard fed by a value-counter model, and hand-written corner sequences.
module tb_dice_roll_sequencer;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;

    dice_roll_sequencer_if dif ();

    dice_roll_sequencer dut (
        .Clock  (Clock),
        .nReset (nReset),
        .dice   (dif)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Value counter model; badAt selects which Step makes it present an illegal 7.
    logic [2:0] cnt       = 3'd1;
    int         stepsSeen = 0;
    int         badAt     = -1;

    assign dif.DiceValue = (stepsSeen == badAt) ? 3'd7 : cnt;

    always @(posedge Clock) begin
        if (dif.Step === 1'b1) begin
            cnt       <= (cnt >= 3'd6) ? 3'd1 : cnt + 3'd1;
            stepsSeen <= stepsSeen + 1;
        end
    end

    function automatic logic [2:0] nextFace(input logic [2:0] f);
        return (f >= 3'd6) ? 3'd1 : f + 3'd1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [2:0] disp;
        logic       err;
    } sb_t;

    sb_t        sbQ[$];
    logic [2:0] expDisp = 3'd1;
    logic       expErr  = 1'b0;

    // Expected display/error pushed when a Step is seen, compared two cycles later.
    initial begin : scoreboard
        bit         h1;
        bit         h2;
        sb_t        e;
        logic [2:0] nf;
        h1 = 1'b0;
        h2 = 1'b0;
        forever begin
            @(negedge Clock);
            if (nReset !== 1'b1) begin
                sbQ.delete();
                expDisp = 3'd1;
                expErr  = 1'b0;
                h1      = 1'b0;
                h2      = 1'b0;
            end else begin
                if (h2) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL sb_underflow actual=empty expected=entry");
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("sb_disp", dif.DispValue, e.disp);
                        checkOutput("sb_error", dif.Error, e.err);
                    end
                end
                if (dif.Step === 1'b1) checkOutput("step_spacing", h1, 0);
                h2 = h1;
                h1 = (dif.Step === 1'b1);
                if (h1) begin
                    nf = nextFace(cnt);
                    if (stepsSeen + 1 == badAt) expErr = 1'b1;
                    else                        expDisp = nf;
                    e.disp = expDisp;
                    e.err  = expErr;
                    sbQ.push_back(e);
                end
            end
        end
    end

    typedef struct {
        string name;
        int    hold;
        int    bad;
        int    expEnter;
        int    expSteps;
        int    expShow;
        int    expSleep;
        int    expBlankLow;
        int    expErr;
    } vec_t;

    vec_t vecs[7];

    // Holds Roll for 'hold' cycles and times the roll as seen on the outputs.
    task automatic applyStimulus(input int hold, output int enterCyc, output int stepsTot,
                                 output int showCyc, output int sleepCyc,
                                 output int blankLow, output int timedOut);
        int c;
        enterCyc = 0; stepsTot = 0; showCyc = 0; sleepCyc = 0; blankLow = 0; timedOut = 0;
        @(negedge Clock);
        dif.Roll = 1'b1;
        c = 0;
        forever begin
            @(negedge Clock);
            c++;
            if (c == hold) dif.Roll = 1'b0;
            if (dif.Step === 1'b1) stepsTot++;
            if (dif.Blank === 1'b0) blankLow++;
            if (enterCyc == 0 && dif.Rolling === 1'b1) enterCyc = c;
            if (enterCyc != 0 && showCyc == 0 && dif.Rolling === 1'b0 && dif.Blank === 1'b0)
                showCyc = c;
            if (enterCyc != 0 && dif.Blank === 1'b1) begin
                sleepCyc = c;
                break;
            end
            if (enterCyc == 0 && c >= 40) break;
            if (c >= 400) begin
                timedOut = 1;
                break;
            end
        end
        dif.Roll = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int enterC, stepsC, showC, sleepC, lowC, tout, c, slowSteps;

        vecs[0] = '{"hold30",     30, 0, 6, 13, 54, 74, 68, 0};
        vecs[1] = '{"glitch3",     3, 0, 0,  0,  0,  0,  0, 0};
        vecs[2] = '{"glitch10",   10, 0, 6,  6, 34, 54, 48, 0};
        vecs[3] = '{"hold4",       4, 0, 6,  4, 28, 48, 42, 0};
        vecs[4] = '{"hold31",     31, 0, 6, 13, 55, 75, 69, 0};
        vecs[5] = '{"bad2nd",     10, 2, 6,  6, 34, 54, 48, 1};
        vecs[6] = '{"stickyerr",  30, 0, 6, 13, 54, 74, 68, 1};

        dif.Roll = 1'b0;
        nReset   = 1'b0;
        repeat (3) @(negedge Clock);
        nReset = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            checkOutput("rst_blank", dif.Blank, 1);
            checkOutput("rst_disp", dif.DispValue, 1);
            checkOutput("rst_step", dif.Step, 0);
            checkOutput("rst_error", dif.Error, 0);
            checkOutput("rst_rolling", dif.Rolling, 0);
        end

        for (int i = 0; i < 7; i++) begin
            badAt = (vecs[i].bad != 0) ? stepsSeen + vecs[i].bad : -1;
            applyStimulus(vecs[i].hold, enterC, stepsC, showC, sleepC, lowC, tout);
            badAt = -1;
            checkOutput({vecs[i].name, "_timeout"}, tout, 0);
            checkOutput({vecs[i].name, "_enter"}, enterC, vecs[i].expEnter);
            checkOutput({vecs[i].name, "_steps"}, stepsC, vecs[i].expSteps);
            checkOutput({vecs[i].name, "_show"}, showC, vecs[i].expShow);
            checkOutput({vecs[i].name, "_sleep"}, sleepC, vecs[i].expSleep);
            checkOutput({vecs[i].name, "_blanklow"}, lowC, vecs[i].expBlankLow);
            checkOutput({vecs[i].name, "_err"}, dif.Error, vecs[i].expErr);
            repeat (3) @(negedge Clock);
        end

        // Press while SHOW timer is 15: back to ROLL, no timeout at SHOW+20.
        @(negedge Clock);
        dif.Roll = 1'b1;
        c = 0;
        sleepC = 0;
        while (sleepC == 0 && c < 400) begin
            @(negedge Clock);
            c++;
            if (c == 49) checkOutput("showpress_before", dif.Rolling, 0);
            if (c == 50) checkOutput("showpress_enter", dif.Rolling, 1);
            if (c == 54) checkOutput("showpress_no_timeout", dif.Blank, 0);
            if (c > 50 && dif.Blank === 1'b1) sleepC = c;
            if (c == 10) dif.Roll = 1'b0;
            if (c == 44) dif.Roll = 1'b1;
            if (c == 54) dif.Roll = 1'b0;
        end
        dif.Roll = 1'b0;
        checkOutput("showpress_sleep", sleepC, 98);
        repeat (3) @(negedge Clock);

        // Press during SLOW is ignored; the slow-down still issues exactly three Steps.
        @(negedge Clock);
        dif.Roll = 1'b1;
        c = 0;
        showC = 0;
        sleepC = 0;
        slowSteps = 0;
        while (sleepC == 0 && c < 400) begin
            @(negedge Clock);
            c++;
            if (c > 16 && showC == 0 && dif.Step === 1'b1) slowSteps++;
            if (c > 16 && showC == 0 && dif.Rolling === 1'b0) showC = c;
            if (showC != 0 && dif.Blank === 1'b1) sleepC = c;
            if (c == 10) dif.Roll = 1'b0;
            if (c == 18) dif.Roll = 1'b1;
            if (c == 22) dif.Roll = 1'b0;
        end
        dif.Roll = 1'b0;
        checkOutput("slowpress_steps", slowSteps, 3);
        checkOutput("slowpress_show", showC, 34);
        checkOutput("slowpress_sleep", sleepC, 54);
        repeat (3) @(negedge Clock);

        // Asynchronous reset mid-ROLL with Roll held, then re-entry as a fresh press.
        @(negedge Clock);
        dif.Roll = 1'b1;
        repeat (20) @(negedge Clock);
        #2 nReset = 1'b0;
        #1;
        checkOutput("async_blank", dif.Blank, 1);
        checkOutput("async_rolling", dif.Rolling, 0);
        checkOutput("async_disp", dif.DispValue, 1);
        checkOutput("async_step", dif.Step, 0);
        checkOutput("async_error", dif.Error, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            checkOutput("async_hold_step", dif.Step, 0);
            checkOutput("async_hold_rolling", dif.Rolling, 0);
        end
        nReset = 1'b1;
        c = 0;
        enterC = 0;
        while (enterC == 0 && c < 50) begin
            @(negedge Clock);
            c++;
            if (dif.Step === 1'b1) checkOutput("reenter_early_step", c, 0);
            if (dif.Rolling === 1'b1) enterC = c;
        end
        checkOutput("reenter_cycle", enterC, 6);
        dif.Roll = 1'b0;
        sleepC = 0;
        while (sleepC == 0 && c < 400) begin
            @(negedge Clock);
            c++;
            if (dif.Blank === 1'b1) sleepC = c;
        end
        checkOutput("reenter_sleep", sleepC, 50);

        repeat (5) @(negedge Clock);
        checkOutput("sb_drain", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
